// File: rtl/irq_pkg.sv
// Shared bus and interrupt definitions: FSM encodings, register offsets, bus modes
// and a small address/mode decode helper used by memory-mapped slaves.
package irq_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_SVC  = 2'b10;

  localparam logic [31:0] OFF_ENABLE  = 32'h0;
  localparam logic [31:0] OFF_PENDING = 32'h4;
  localparam logic [31:0] OFF_STATUS  = 32'h8;
  localparam logic [31:0] OFF_SWTRIG  = 32'hC;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;
  localparam logic [1:0] MODE_NONE  = 2'b11;

  typedef struct packed {
    logic rd;
    logic wr;
    logic sel_enable;
    logic sel_pending;
    logic sel_status;
    logic sel_swtrig;
  } bus_dec_t;

  // Only exact word offsets decode; any other address (including misaligned) is ignored.
  function automatic bus_dec_t bus_decode(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [1:0]  mode);
    bus_dec_t    d;
    logic [31:0] off;
    logic        hit;
    d             = '0;
    off           = addr - base;
    d.sel_enable  = (off == OFF_ENABLE);
    d.sel_pending = (off == OFF_PENDING);
    d.sel_status  = (off == OFF_STATUS);
    d.sel_swtrig  = (off == OFF_SWTRIG);
    hit = d.sel_enable | d.sel_pending | d.sel_status | d.sel_swtrig;
    case (mode)
      MODE_READ:            d.rd = hit;
      MODE_WRITE:           d.wr = hit;
      MODE_IDLE, MODE_NONE: ;
      default:              ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins, valid flags any request.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SOURCES = 8,
  parameter int VECTOR_W    = 3
) (
  input  logic [NUM_SOURCES-1:0] req,
  output logic                   valid,
  output logic [VECTOR_W-1:0]    index
);

  // Scan from the top down so the lowest index is the last (winning) assignment.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = VECTOR_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: falling-edge capture into PENDING, fixed-priority
// dispatch and a single-outstanding request/ack/eoi handshake with the core.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [31:0] base_address = 32'h40C0,
  parameter int          NUM_SOURCES  = 8,
  parameter int          VECTOR_W     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  inout  wire  [31:0]            data_bus_data,
  input  logic [31:0]            data_bus_addr,
  input  logic [1:0]             data_bus_mode,
  input  logic [NUM_SOURCES-1:0] irq_n,
  output logic                   cpu_irq,
  output logic [VECTOR_W-1:0]    cpu_irq_vector,
  input  logic                   cpu_irq_ack,
  input  logic                   cpu_irq_eoi
);

  // Core handshake: cpu_irq is a level held for the whole of REQ with a frozen vector;
  // the core answers with a one-cycle ack (taken only in REQ), later a one-cycle eoi
  // (taken only in SVC). Pulses seen in any other state are dropped.

  logic [NUM_SOURCES-1:0] irq_n_q;
  logic                   edge_armed;
  logic [NUM_SOURCES-1:0] enable;
  logic [NUM_SOURCES-1:0] pending;
  logic [1:0]             state;
  logic [VECTOR_W-1:0]    vector;

  bus_dec_t               dec;
  logic [NUM_SOURCES-1:0] wr_data;
  logic [NUM_SOURCES-1:0] fall;
  logic [NUM_SOURCES-1:0] sw_set;
  logic [NUM_SOURCES-1:0] w1c_clr;
  logic [NUM_SOURCES-1:0] ack_clr;
  logic [NUM_SOURCES-1:0] pending_next;
  logic [NUM_SOURCES-1:0] eligible;
  logic                   win_valid;
  logic [VECTOR_W-1:0]    win_index;
  logic                   ack_take;
  logic                   eoi_take;
  logic [31:0]            rd_data;
  logic                   unused_bus_bits;

  assign dec             = bus_decode(data_bus_addr, base_address, data_bus_mode);
  assign wr_data         = data_bus_data[NUM_SOURCES-1:0];
  assign unused_bus_bits = ^data_bus_data[31:NUM_SOURCES];

  // Edge detection stays disarmed for the first cycle after reset so a line that is
  // already low when reset releases is not mistaken for a fresh falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_n_q    <= '1;
      edge_armed <= 1'b0;
    end else begin
      irq_n_q    <= irq_n;
      edge_armed <= 1'b1;
    end
  end

  assign fall    = edge_armed ? (irq_n_q & ~irq_n) : '0;
  assign sw_set  = (dec.wr && dec.sel_swtrig) ? wr_data : '0;
  assign w1c_clr = (dec.wr && dec.sel_pending) ? wr_data : '0;

  assign ack_take = (state == ST_REQ) && cpu_irq_ack;
  assign eoi_take = (state == ST_SVC) && cpu_irq_eoi;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      ack_clr[i] = ack_take && (vector == VECTOR_W'(i));
    end
  end

  // Any set source (edge or software) overrides any clear source on the same bit.
  assign pending_next = (pending & ~(w1c_clr | ack_clr)) | fall | sw_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      enable  <= '0;
    end else begin
      pending <= pending_next;
      if (dec.wr && dec.sel_enable) begin
        enable <= wr_data;
      end
    end
  end

  assign eligible = pending & enable;

  irq_prio_enc #(
    .NUM_SOURCES (NUM_SOURCES),
    .VECTOR_W    (VECTOR_W)
  ) u_prio_enc (
    .req   (eligible),
    .valid (win_valid),
    .index (win_index)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      vector <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            vector <= win_index;
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_take) begin
            state <= ST_SVC;
          end
        end
        ST_SVC: begin
          if (eoi_take) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_irq        = (state == ST_REQ);
  assign cpu_irq_vector = vector;

  always_comb begin
    rd_data = '0;
    if (dec.sel_enable) begin
      rd_data[NUM_SOURCES-1:0] = enable;
    end else if (dec.sel_pending) begin
      rd_data[NUM_SOURCES-1:0] = pending;
    end else if (dec.sel_status) begin
      rd_data[1:0]            = state;
      rd_data[8 +: VECTOR_W]  = vector;
    end
  end

  assign data_bus_data = dec.rd ? rd_data : 'z;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a behavioural model of the controller.
module tb_irq_controller;

  localparam logic [31:0] BASE = 32'h40C0;
  localparam logic [31:0] A_EN = BASE + 32'h0;
  localparam logic [31:0] A_PD = BASE + 32'h4;
  localparam logic [31:0] A_ST = BASE + 32'h8;
  localparam logic [31:0] A_SW = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  wire  [31:0] data_bus_data;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  irq_n = 8'hFF;
  logic        ack = 1'b0;
  logic        eoi = 1'b0;
  logic        cpu_irq;
  logic [2:0]  cpu_irq_vector;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  assign data_bus_data = (mode == 2'b10) ? wdata : 'z;

  irq_controller #(
    .base_address (BASE),
    .NUM_SOURCES  (8),
    .VECTOR_W     (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_bus_data  (data_bus_data),
    .data_bus_addr  (addr),
    .data_bus_mode  (mode),
    .irq_n          (irq_n),
    .cpu_irq        (cpu_irq),
    .cpu_irq_vector (cpu_irq_vector),
    .cpu_irq_ack    (ack),
    .cpu_irq_eoi    (eoi)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, act=timeout req=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Behavioural reference model
  logic [7:0] m_q;
  logic       m_armed;
  logic [7:0] m_pend;
  logic [7:0] m_en;
  int         m_state;   // 0 idle, 1 request outstanding, 2 in service
  int         m_vec;

  task automatic model_reset();
    m_q = 8'hFF; m_armed = 1'b0; m_pend = '0; m_en = '0; m_state = 0; m_vec = 0;
  endtask

  function automatic bit decoded(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off < 32'd16) && (off[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off == 32'h0) return {24'h0, m_en};
    if (off == 32'h4) return {24'h0, m_pend};
    if (off == 32'h8) return 32'(m_vec) * 256 + 32'(m_state);
    return 32'h0;
  endfunction

  task automatic model_step();
    logic [7:0]  set_b;
    logic [7:0]  clr_b;
    logic [7:0]  elig;
    logic [31:0] off;
    bit          wr;
    off   = addr - BASE;
    wr    = (mode == 2'b10);
    set_b = m_armed ? (m_q & ~irq_n) : 8'h00;
    clr_b = 8'h00;
    if (wr && off == 32'hC) set_b = set_b | wdata[7:0];
    if (wr && off == 32'h4) clr_b = wdata[7:0];
    elig = m_pend & m_en;
    if (m_state == 0) begin
      for (int i = 7; i >= 0; i--) if (elig[i]) m_vec = i;
      if (elig != 0) m_state = 1;
    end else if (m_state == 1) begin
      if (ack) begin
        clr_b[m_vec] = 1'b1;
        m_state = 2;
      end
    end else if (eoi) begin
      m_state = 0;
    end
    m_pend = (m_pend & ~clr_b) | set_b;
    if (wr && off == 32'h0) m_en = wdata[7:0];
    m_q = irq_n;
    m_armed = 1'b1;
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=0x%08h req=0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick_body();
    if (mode == 2'b01 && decoded(addr)) begin
      exp_q.push_back(model_read(addr));
      check("model_read", data_bus_data, exp_q.pop_front());
    end
    model_step();
    @(posedge clk);
    #1;
    check("model_cpu_irq", {31'h0, cpu_irq}, (m_state == 1) ? 32'h1 : 32'h0);
    check("model_vector", {29'h0, cpu_irq_vector}, 32'(m_vec));
    mode = 2'b00; ack = 1'b0; eoi = 1'b0;
  endtask

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    tick_body();
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    mode = 2'b10; addr = a; wdata = d;
    tick();
  endtask

  task automatic bus_rd(input string name, input logic [31:0] a, input logic [31:0] req);
    mode = 2'b01; addr = a;
    #2;
    check(name, data_bus_data, req);
    tick();
  endtask

  task automatic reset_release();
    @(negedge clk);
    reset = 1'b1;
    tick_body();
  endtask

  typedef struct {
    logic [7:0]  irq_n;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        eoi;
    logic [31:0] exp_rd;
    logic        exp_irq;
    logic [2:0]  exp_vec;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic [7:0] n, input logic [1:0] md, input logic [31:0] a,
                              input logic [31:0] d, input logic ak, input logic eo,
                              input logic [31:0] rd, input logic ei, input logic [2:0] ev);
    vec_t v;
    v.irq_n = n; v.mode = md; v.addr = a; v.wdata = d; v.ack = ak; v.eoi = eo;
    v.exp_rd = rd; v.exp_irq = ei; v.exp_vec = ev;
    return v;
  endfunction

  initial begin
    // Directed sequence: single source handshake, then simultaneous sources 5 and 2
    tbl[0]  = mk(8'hFF, 2'b10, A_EN, 32'h01, 0, 0, 0,         0, 0);
    tbl[1]  = mk(8'hFE, 2'b00, A_EN, 0,      0, 0, 0,         0, 0);
    tbl[2]  = mk(8'hFE, 2'b01, A_PD, 0,      0, 0, 32'h01,    1, 0);
    tbl[3]  = mk(8'hFE, 2'b01, A_ST, 0,      0, 0, 32'h01,    1, 0);
    tbl[4]  = mk(8'hFE, 2'b00, A_EN, 0,      1, 0, 0,         0, 0);
    tbl[5]  = mk(8'hFE, 2'b01, A_PD, 0,      0, 0, 32'h00,    0, 0);
    tbl[6]  = mk(8'hFE, 2'b01, A_ST, 0,      0, 0, 32'h02,    0, 0);
    tbl[7]  = mk(8'hFE, 2'b00, A_EN, 0,      0, 1, 0,         0, 0);
    tbl[8]  = mk(8'hFE, 2'b01, A_ST, 0,      0, 0, 32'h00,    0, 0);
    tbl[9]  = mk(8'hFF, 2'b00, A_EN, 0,      0, 0, 0,         0, 0);
    tbl[10] = mk(8'hFF, 2'b10, A_EN, 32'hFF, 0, 0, 0,         0, 0);
    tbl[11] = mk(8'hDB, 2'b00, A_EN, 0,      0, 0, 0,         0, 0);
    tbl[12] = mk(8'hDB, 2'b00, A_EN, 0,      0, 0, 0,         1, 2);
    tbl[13] = mk(8'hDB, 2'b01, A_PD, 0,      0, 0, 32'h24,    1, 2);
    tbl[14] = mk(8'hDB, 2'b00, A_EN, 0,      1, 0, 0,         0, 2);
    tbl[15] = mk(8'hDB, 2'b00, A_EN, 0,      0, 1, 0,         0, 2);
    tbl[16] = mk(8'hDB, 2'b00, A_EN, 0,      0, 0, 0,         1, 5);
    tbl[17] = mk(8'hDB, 2'b00, A_EN, 0,      1, 0, 0,         0, 5);
    tbl[18] = mk(8'hFF, 2'b00, A_EN, 0,      0, 1, 0,         0, 5);
    tbl[19] = mk(8'hFF, 2'b01, A_PD, 0,      0, 0, 32'h00,    0, 5);
    tbl[20] = mk(8'hFF, 2'b00, A_EN, 0,      1, 0, 0,         0, 5);
    tbl[21] = mk(8'hFF, 2'b01, A_ST, 0,      0, 0, 32'h500,   0, 5);

    // Reset
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_cpu_irq", {31'h0, cpu_irq}, 32'h0);
    check("reset_vector", {29'h0, cpu_irq_vector}, 32'h0);
    reset_release();
    bus_rd("reset_enable", A_EN, 32'h0);
    bus_rd("reset_pending", A_PD, 32'h0);
    bus_rd("reset_status", A_ST, 32'h0);

    // Table-driven vectors
    for (int i = 0; i < 22; i++) begin
      irq_n = tbl[i].irq_n; mode = tbl[i].mode; addr = tbl[i].addr; wdata = tbl[i].wdata;
      ack = tbl[i].ack; eoi = tbl[i].eoi;
      #2;
      if (tbl[i].mode == 2'b01) check($sformatf("tbl%0d_read", i), data_bus_data, tbl[i].exp_rd);
      tick();
      check($sformatf("tbl%0d_cpu_irq", i), {31'h0, cpu_irq}, {31'h0, tbl[i].exp_irq});
      check($sformatf("tbl%0d_vector", i), {29'h0, cpu_irq_vector}, {29'h0, tbl[i].exp_vec});
    end

    // Disabled source latches pending, dispatches once enabled; disable in REQ does not withdraw
    bus_wr(A_EN, 32'h0);
    irq_n = 8'hF7; tick();
    irq_n = 8'hFF; tick();
    bus_rd("t3_pending", A_PD, 32'h08);
    tick(); tick();
    check("t3_no_irq", {31'h0, cpu_irq}, 32'h0);
    bus_wr(A_EN, 32'h08);
    tick();
    check("t3_irq", {31'h0, cpu_irq}, 32'h1);
    check("t3_vector", {29'h0, cpu_irq_vector}, 32'h3);
    bus_wr(A_EN, 32'h0);
    check("t3_no_withdraw", {31'h0, cpu_irq}, 32'h1);
    ack = 1'b1; tick();
    eoi = 1'b1; tick();

    // Set beats W1C on the same bit; W1C alone clears; SWTRIG sets and reads 0
    irq_n = 8'hEF; tick();
    irq_n = 8'hFF; tick();
    irq_n = 8'hEF; mode = 2'b10; addr = A_PD; wdata = 32'h10; tick();
    bus_rd("t4_set_wins", A_PD, 32'h10);
    irq_n = 8'hFF; tick();
    bus_wr(A_PD, 32'h10);
    bus_rd("t4_w1c", A_PD, 32'h00);
    bus_wr(A_SW, 32'h40);
    bus_rd("t4_swtrig", A_PD, 32'h40);
    bus_rd("t4_swtrig_reads0", A_SW, 32'h00);

    // STATUS in REQ, stray eoi, undecoded accesses, mode 11, stray ack
    bus_wr(A_EN, 32'h40);
    tick();
    bus_rd("t6_status", A_ST, 32'h601);
    eoi = 1'b1; tick();
    check("t6_eoi_in_req", {31'h0, cpu_irq}, 32'h1);
    mode = 2'b01; addr = BASE + 32'h10;
    #2;
    check("t6_undecoded_rd", (data_bus_data === 32'h40 || data_bus_data === 32'h601) ? 32'h1 : 32'h0, 32'h0);
    tick();
    bus_wr(BASE + 32'h10, 32'hFF);
    mode = 2'b11; addr = A_EN; tick();
    bus_rd("t6_enable_kept", A_EN, 32'h40);
    ack = 1'b1; tick();
    eoi = 1'b1; tick();
    ack = 1'b1; tick();
    bus_rd("t6_ack_in_idle", A_ST, 32'h600);

    // Reset in SVC with a source held low across deassert
    bus_wr(A_SW, 32'h40);
    tick();
    ack = 1'b1; tick();
    bus_rd("t5_in_svc", A_ST, 32'h602);
    #2;
    irq_n = 8'hFD;
    reset = 1'b0;
    model_reset();
    #1;
    check("t5_async_cpu_irq", {31'h0, cpu_irq}, 32'h0);
    check("t5_async_vector", {29'h0, cpu_irq_vector}, 32'h0);
    repeat (2) @(posedge clk);
    reset_release();
    bus_rd("t5_status", A_ST, 32'h0);
    bus_rd("t5_enable", A_EN, 32'h0);
    tick();
    bus_rd("t5_no_pending", A_PD, 32'h0);
    irq_n = 8'hFF; tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int op;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) irq_n[b] = ~irq_n[b];
      op = int'($urandom_range(0, 9));
      if (op <= 2) begin
        mode = 2'b10; addr = BASE + 32'($urandom_range(0, 3)) * 4;
        wdata = (addr == A_SW) ? (32'h1 << $urandom_range(0, 7)) : $urandom;
      end else if (op <= 5) begin
        mode = 2'b01; addr = BASE + 32'($urandom_range(0, 3)) * 4;
      end else if (op == 6) begin
        mode = 2'b10; addr = BASE + 32'h10 + 32'($urandom_range(0, 3)) * 4; wdata = $urandom;
      end else if (op == 7) begin
        mode = 2'b11; addr = BASE + 32'($urandom_range(0, 3)) * 4;
      end
      ack = ($urandom_range(0, 3) == 0);
      eoi = ($urandom_range(0, 3) == 0);
      tick();
    end

    // Report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
